blend_stream_sequencer: RTL
===========================

Name: blend_stream_sequencer

Overview:
- Upstream feeder for the image blender.
- Accepts one frame configuration (divisor, two blend ratios) and a handshaked stream of pixel pairs, and serialises them into the blender's 18-bit command word {state[1:0], data_1[7:0], data_2[7:0]}.
- Tracks the blender's fixed pipeline latency so it can flag which blender output cycles carry valid blended pixels.
- Holds off a new configuration until in-flight results have drained, so a divisor change never corrupts results still in the pipeline.

Parameters:
PIPE_LAT, 3, cycles from a pixel word being driven on single_input to the matching blended result at the blender data_out (register-to-data_out delay of the blender)
CNT_W, 16, width of the per-frame pixel counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted when high with cfg_valid
cfg_divisor  input  3  blender divisor select 0..7
cfg_ratio1  input  8  ratio for channel 1
cfg_ratio2  input  8  ratio for channel 2
pix_valid  input  1  pixel pair offered
pix_ready  output  1  pixel pair accepted when high with pix_valid
pix_a  input  8  channel-1 pixel
pix_b  input  8  channel-2 pixel
pix_last  input  1  final pair of the frame
single_input  output  18  registered command word to the blender
blend_valid  output  1  blender data_out holds a valid result this cycle
blend_last  output  1  qualifies blend_valid for the frame's final result
pix_count  output  CNT_W  pairs issued in the current frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Command encodings, in bits 17:16 / 15:8 / 7:0:
  - DIV = 01 / {5'b0, div} / 0
  - RATIO = 10 / r1 / r2
  - PIXEL = 00 / a / b
  - IDLE = 11 / 0 / 0, i.e. 18'h30000; the blender holds all registers on this word.
- State register and all outputs are registered. The state machine is IDLE -> LOAD_DIV -> LOAD_RATIO -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - cfg_ready=1, pix_ready=0, single_input=IDLE word.
  - On cfg_valid&cfg_ready: capture divisor and ratios, clear pix_count, go to LOAD_DIV.
- LOAD_DIV: drive the DIV word for exactly 1 cycle, then go to LOAD_RATIO.
- LOAD_RATIO: drive the RATIO word for exactly 1 cycle, then go to STREAM. Pixels may follow immediately; the ratio lands in the blender before the first pixel.
- STREAM:
  - pix_ready=1. The word driven in the cycle after acceptance is PIXEL{a,b}.
  - If no pair is accepted, drive the IDLE word (bubble).
  - pix_count increments on every accept, saturating at all-ones.
  - An accept with pix_last=1 moves to DRAIN; pix_ready is 0 from that point on.
- DRAIN:
  - Drive the IDLE word; pix_ready=0, cfg_ready=0.
  - Leave DRAIN at the end of the cycle in which blend_last=1; IDLE is entered the next cycle.
- Valid tracking:
  - A PIPE_LAT-deep shift register is loaded with {1, last} in each cycle single_input carries a PIXEL word, and {0, 0} otherwise.
  - blend_valid/blend_last appear exactly PIPE_LAT cycles after that word's drive cycle.
  - Bubbles never produce blend_valid.
- busy is high in all states except IDLE.
- cfg_valid outside IDLE is ignored; the request stays pending with cfg_ready=0.
- pix_valid outside STREAM is ignored.
- A zero-length frame cannot occur: at least one pair ends each frame.
- Reset values, asynchronous assertion mid-operation included:
  - State returns to IDLE.
  - single_input=18'h30000, blend_valid=0, blend_last=0, pix_count=0, cfg_ready=1 after reset, pix_ready=0, busy=0.
  - The shift register clears, so in-flight results are discarded.
- Reset release is not synchronised internally; it is synchronised upstream.
- Config captured on the accept edge is held stable until the next accept.

Test Plan:
- Basic frame: cfg div=1, r1=0x80, r2=0x40, one pair a=0xC8, b=0x64 with last.
  - single_input sequence: 18'h10100, 18'h28040, 18'h0C864, then 18'h30000.
  - blend_valid=blend_last=1 exactly 3 cycles after the 0x0C864 cycle; pix_count=1; cfg_ready returns 1 the next cycle.
- Back-to-back stream: 4 pairs with pix_valid held high.
  - 4 consecutive PIXEL words, 4 consecutive blend_valid cycles; blend_last only on the 4th; pix_count=4.
- Bubbles: pix_valid pattern 1,0,0,1(last).
  - Words PIXEL, IDLE, IDLE, PIXEL; blend_valid pattern 1,0,0,1 offset by 3 cycles.
- Config during busy: cfg_valid held high from LOAD_DIV through DRAIN.
  - cfg_ready stays 0, and no DIV word appears, until the cycle after blend_last.
  - The second config is then accepted and the next DIV word is issued.
- Reset mid-stream: assert rst after 2 of 5 pairs accepted.
  - Same cycle: single_input=18'h30000, blend_valid=0, pix_count=0, busy=0.
  - After release: cfg_ready=1 and no stale blend_valid.
- Counter saturation with CNT_W=4: 20 pairs.
  - pix_count stops at 15; blend_valid count is still 20.

Source files
------------

// File: rtl/blend_stream_sequencer.sv
// ---------------------------------------------------------------------------
// blend_stream_sequencer
//   Upstream feeder for the image blender. Takes one frame configuration and
//   a handshaked stream of pixel pairs, and turns them into the blender's
//   18-bit command word {state[1:0], data_1[7:0], data_2[7:0]}. It models the
//   blender's fixed pipeline latency to flag which blender output cycles hold
//   valid results. It does not take a new configuration until the last result
//   of the current frame has left the blender.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cfg_valid/ready   configuration handshake (accepted only in IDLE)
//   cfg_divisor       blender divisor select 0..7
//   cfg_ratio1/2      blend ratios for channel 1 / channel 2
//   pix_valid/ready   pixel-pair handshake
//   pix_a, pix_b      channel-1 / channel-2 pixel
//   pix_last          final pair of the frame
//   single_input      registered command word to the blender
//   blend_valid       blender data_out holds a valid result this cycle
//   blend_last        blend_valid result is the frame's final one
//   pix_count         pairs issued in the current frame (saturating)
//   busy              high in every state except IDLE
// ---------------------------------------------------------------------------
module blend_stream_sequencer #(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_divisor,
    input  logic [7:0]       cfg_ratio1,
    input  logic [7:0]       cfg_ratio2,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [7:0]       pix_a,
    input  logic [7:0]       pix_b,
    input  logic             pix_last,
    output logic [17:0]      single_input,
    output logic             blend_valid,
    output logic             blend_last,
    output logic [CNT_W-1:0] pix_count,
    output logic             busy
);

    localparam int unsigned WORD_W = 18;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] CMD_PIXEL = 2'b00;
    localparam logic [1:0] CMD_DIV   = 2'b01;
    localparam logic [1:0] CMD_RATIO = 2'b10;
    localparam logic [1:0] CMD_IDLE  = 2'b11;

    localparam logic [WORD_W-1:0] IDLE_WORD = {CMD_IDLE, 16'h0000};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_DIV   = 3'd1,
        S_LOAD_RATIO = 3'd2,
        S_STREAM     = 3'd3,
        S_DRAIN      = 3'd4
    } state_e;

    state_e state_q;
    state_e state_d;

    // Registered outputs and their next values
    logic [WORD_W-1:0] single_input_q;
    logic [WORD_W-1:0] single_input_d;
    logic              last_word_q;
    logic              last_word_d;
    logic              cfg_ready_q;
    logic              cfg_ready_d;
    logic              pix_ready_q;
    logic              pix_ready_d;
    logic              busy_q;
    logic              busy_d;
    logic [CNT_W-1:0]  pix_count_q;
    logic [CNT_W-1:0]  pix_count_d;

    // Captured ratios; the divisor goes straight into the DIV command word
    logic [DATA_W-1:0] ratio1_q;
    logic [DATA_W-1:0] ratio1_d;
    logic [DATA_W-1:0] ratio2_q;
    logic [DATA_W-1:0] ratio2_d;

    // Blender latency model: one {valid, last} bit pair per pipeline stage
    logic [PIPE_LAT-1:0] vld_sr_q;
    logic [PIPE_LAT-1:0] lst_sr_q;

    logic cfg_acc;
    logic pix_acc;
    logic pix_word;

    assign cfg_acc  = cfg_valid & cfg_ready_q;
    assign pix_acc  = pix_valid & pix_ready_q;
    assign pix_word = (single_input_q[WORD_W-1 -: 2] == CMD_PIXEL);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_acc) begin
                    state_d = S_LOAD_DIV;
                end
            end
            S_LOAD_DIV: begin
                state_d = S_LOAD_RATIO;
            end
            // A pair may already be taken while RATIO is on the bus, so a
            // one-pair frame can go straight to DRAIN.
            S_LOAD_RATIO: begin
                if (pix_acc && pix_last) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pix_acc && pix_last) begin
                    state_d = S_DRAIN;
                end
            end
            // blend_last marks the last in-flight result leaving the blender
            S_DRAIN: begin
                if (lst_sr_q[PIPE_LAT-1]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output / datapath next values; handshake readies follow the next state
    always_comb begin
        single_input_d = IDLE_WORD;
        last_word_d    = 1'b0;
        cfg_ready_d    = (state_d == S_IDLE);
        pix_ready_d    = (state_d == S_LOAD_RATIO) || (state_d == S_STREAM);
        busy_d         = (state_d != S_IDLE);
        pix_count_d    = pix_count_q;
        ratio1_d       = ratio1_q;
        ratio2_d       = ratio2_q;

        if (cfg_acc) begin
            single_input_d = {CMD_DIV, 5'b00000, cfg_divisor, 8'h00};
            ratio1_d       = cfg_ratio1;
            ratio2_d       = cfg_ratio2;
            pix_count_d    = '0;
        end

        if (state_q == S_LOAD_DIV) begin
            single_input_d = {CMD_RATIO, ratio1_q, ratio2_q};
        end

        // An accepted pair becomes the PIXEL word in the following cycle
        if (pix_acc) begin
            single_input_d = {CMD_PIXEL, pix_a, pix_b};
            last_word_d    = pix_last;
            if (pix_count_q != {CNT_W{1'b1}}) begin
                pix_count_d = pix_count_q + CNT_W'(1);
            end
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            single_input_q <= IDLE_WORD;
            last_word_q    <= 1'b0;
            cfg_ready_q    <= 1'b1;
            pix_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            pix_count_q    <= '0;
            ratio1_q       <= '0;
            ratio2_q       <= '0;
        end else begin
            single_input_q <= single_input_d;
            last_word_q    <= last_word_d;
            cfg_ready_q    <= cfg_ready_d;
            pix_ready_q    <= pix_ready_d;
            busy_q         <= busy_d;
            pix_count_q    <= pix_count_d;
            ratio1_q       <= ratio1_d;
            ratio2_q       <= ratio2_d;
        end
    end

    // Latency model: a PIXEL word on the bus in cycle T reaches the last
    // stage, and therefore blend_valid, in cycle T + PIPE_LAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_q <= '0;
            lst_sr_q <= '0;
        end else begin
            vld_sr_q[0] <= pix_word;
            lst_sr_q[0] <= pix_word & last_word_q;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
                lst_sr_q[i] <= lst_sr_q[i-1];
            end
        end
    end

    assign single_input = single_input_q;
    assign cfg_ready    = cfg_ready_q;
    assign pix_ready    = pix_ready_q;
    assign busy         = busy_q;
    assign pix_count    = pix_count_q;
    assign blend_valid  = vld_sr_q[PIPE_LAT-1];
    assign blend_last   = lst_sr_q[PIPE_LAT-1];

endmodule
